// File: rtl/ecc_secded_pipe_pkg.sv
// ecc_pkg: shared definitions for the SEC-DED Hamming decoder and its
// write-side encoder.
//   calc_p    - Hamming check-bit count for a given data width
//   is_pow2   - true when the argument is a nonzero power of two
//   data_pos  - codeword position (1-based) of data bit idx
//   ecc_class_e - classification of a decoded word
package ecc_pkg;

    typedef enum logic [1:0] {
        CLEAN    = 2'd0,
        SEC_DATA = 2'd1,
        SEC_CHK  = 2'd2,
        DED      = 2'd3
    } ecc_class_e;

    function automatic bit is_pow2(input int x);
        return (x != 0) && ((x & (x - 1)) == 0);
    endfunction

    // Smallest P with 2^P >= dw + P + 1.
    function automatic int calc_p(input int dw);
        int p;
        p = 0;
        for (int i = 1; i < 8; i++) begin
            if (p == 0 && (1 << i) >= dw + i + 1) p = i;
        end
        return p;
    endfunction

    // Data bits occupy the non-power-of-two positions in ascending order:
    // d0@3, d1@5, d2@6, d3@7, d4@9 ...
    function automatic int data_pos(input int idx);
        int pos;
        int cnt;
        pos = 0;
        cnt = 0;
        for (int k = 3; k < 128; k++) begin
            if (!is_pow2(k)) begin
                if (cnt == idx && pos == 0) pos = k;
                cnt++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/ecc_secded_pipe_if.sv
// ecc_secded_pipe_if: valid/ready stream bundle for the SEC-DED decoder.
//   Input side : in_valid, in_ready, in_data, in_chk (bit P = overall parity),
//                corr_en (sampled with the word)
//   Output side: out_valid, out_ready, out_data, out_sec, out_ded
//   slave modport  - the decoder
//   master modport - the producer/consumer driving the decoder
interface ecc_secded_pipe_if
    import ecc_pkg::*;
#(
    parameter int DW = 32
);
    localparam int CW = calc_p(DW) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_chk;
    logic          corr_en;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_sec;
    logic          out_ded;

    modport slave (
        input  in_valid, in_data, in_chk, corr_en, out_ready,
        output in_ready, out_valid, out_data, out_sec, out_ded
    );

    modport master (
        output in_valid, in_data, in_chk, corr_en, out_ready,
        input  in_ready, out_valid, out_data, out_sec, out_ded
    );

endinterface

// File: rtl/ecc_secded_enc.sv
// ecc_secded_enc: combinational SEC-DED Hamming encoder.
//   data [DW-1:0] - data word
//   chk  [P:0]    - check bits; chk[i] (i<P) covers data bits whose position
//                   has bit i set, chk[P] is overall parity of data + chk[P-1:0]
// Shared between the read-side syndrome recompute and the write-side encoder.
module ecc_secded_enc
    import ecc_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0]        data,
    output logic [calc_p(DW):0]  chk
);

    localparam int P = calc_p(DW);

    always_comb begin
        chk = '0;
        for (int j = 0; j < DW; j++) begin
            for (int i = 0; i < P; i++) begin
                if (((data_pos(j) >> i) & 1) == 1) chk[i] = chk[i] ^ data[j];
            end
        end
        chk[P] = (^data) ^ (^chk[P-1:0]);
    end

endmodule

// File: rtl/ecc_secded_pipe.sv
// ecc_secded_pipe: two-stage pipelined SEC-DED Hamming decoder with
// valid/ready backpressure and saturating error counters.
//   clk, rst        - clock, asynchronous active-high reset
//   bus (slave)     - input word/check bits/corr_en and corrected output
//                     with out_sec / out_ded flags
//   cnt_clr         - synchronous clear of both counters (wins over increment)
//   sec_cnt/ded_cnt - saturating counts of delivered SEC / DED results
module ecc_secded_pipe
    import ecc_pkg::*;
#(
    parameter int DW   = 32,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    ecc_secded_pipe_if.slave bus,
    input  logic            cnt_clr,
    output logic [CNTW-1:0] sec_cnt,
    output logic [CNTW-1:0] ded_cnt
);

    localparam int P    = calc_p(DW);
    localparam int CW   = P + 1;
    localparam int NPOS = DW + P;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic [CW-1:0] chk_calc;
    logic [P-1:0]  syn_p0;
    logic          par_p0;

    logic          load_p2, in_ready_c, in_fire, out_fire;

    logic          vld_p1_q, vld_p1_d;
    logic [DW-1:0] data_p1_q, data_p1_d;
    logic [P-1:0]  syn_p1_q, syn_p1_d;
    logic          par_p1_q, par_p1_d;
    logic          corr_p1_q, corr_p1_d;

    ecc_class_e    cls_p1;
    logic [DW-1:0] flip_p1;

    logic          vld_p2_q, vld_p2_d;
    logic [DW-1:0] data_p2_q, data_p2_d;
    logic          sec_p2_q, sec_p2_d;
    logic          ded_p2_q, ded_p2_d;

    logic [CNTW-1:0] sec_cnt_q, sec_cnt_d;
    logic [CNTW-1:0] ded_cnt_q, ded_cnt_d;

    ecc_secded_enc #(.DW(DW)) u_enc (
        .data (bus.in_data),
        .chk  (chk_calc)
    );

    // ---- stage 0: syndrome and overall parity of the incoming word ----
    // Overall parity of data+chk equals the recomputed/received chk[P]
    // difference folded with the syndrome parity.
    always_comb begin
        syn_p0 = bus.in_chk[P-1:0] ^ chk_calc[P-1:0];
        par_p0 = bus.in_chk[P] ^ chk_calc[P] ^ (^syn_p0);
    end

    // Handshake: a stage loads when empty or when its contents are leaving.
    always_comb begin
        load_p2    = !vld_p2_q || bus.out_ready;
        in_ready_c = !vld_p1_q || load_p2;
        in_fire    = bus.in_valid && in_ready_c;
        out_fire   = vld_p2_q && bus.out_ready;
    end

    always_comb begin
        vld_p1_d  = in_fire || (vld_p1_q && !load_p2);
        data_p1_d = in_fire ? bus.in_data : data_p1_q;
        syn_p1_d  = in_fire ? syn_p0      : syn_p1_q;
        par_p1_d  = in_fire ? par_p0      : par_p1_q;
        corr_p1_d = in_fire ? bus.corr_en : corr_p1_q;
    end

    // ---- stage 1 -> 2: classify and correct ----
    always_comb begin
        cls_p1  = CLEAN;
        flip_p1 = '0;
        if (!par_p1_q) begin
            cls_p1 = (syn_p1_q == '0) ? CLEAN : DED;
        end else if (syn_p1_q == '0 || is_pow2(int'(syn_p1_q))) begin
            cls_p1 = SEC_CHK;
        end else if (int'(syn_p1_q) <= NPOS) begin
            cls_p1 = SEC_DATA;
        end else begin
            cls_p1 = DED;
        end
        for (int j = 0; j < DW; j++) begin
            if (data_pos(j) == int'(syn_p1_q)) flip_p1[j] = 1'b1;
        end
    end

    always_comb begin
        vld_p2_d  = load_p2 ? vld_p1_q : vld_p2_q;
        data_p2_d = data_p2_q;
        sec_p2_d  = sec_p2_q;
        ded_p2_d  = ded_p2_q;
        if (load_p2 && vld_p1_q) begin
            data_p2_d = (cls_p1 == SEC_DATA && corr_p1_q) ? (data_p1_q ^ flip_p1) : data_p1_q;
            sec_p2_d  = (cls_p1 == SEC_DATA) || (cls_p1 == SEC_CHK);
            ded_p2_d  = (cls_p1 == DED);
        end
    end

    // ---- counters on the output handshake ----
    always_comb begin
        sec_cnt_d = sec_cnt_q;
        ded_cnt_d = ded_cnt_q;
        if (cnt_clr) begin
            sec_cnt_d = '0;
            ded_cnt_d = '0;
        end else if (out_fire) begin
            if (sec_p2_q) sec_cnt_d = sat_inc(sec_cnt_q);
            if (ded_p2_q) ded_cnt_d = sat_inc(ded_cnt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            data_p2_q <= '0;
            sec_p2_q  <= 1'b0;
            ded_p2_q  <= 1'b0;
            sec_cnt_q <= '0;
            ded_cnt_q <= '0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
            data_p2_q <= data_p2_d;
            sec_p2_q  <= sec_p2_d;
            ded_p2_q  <= ded_p2_d;
            sec_cnt_q <= sec_cnt_d;
            ded_cnt_q <= ded_cnt_d;
        end
    end

    // Stage-1 payload is qualified by vld_p1_q, so it needs no reset.
    always_ff @(posedge clk) begin
        data_p1_q <= data_p1_d;
        syn_p1_q  <= syn_p1_d;
        par_p1_q  <= par_p1_d;
        corr_p1_q <= corr_p1_d;
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = vld_p2_q;
    assign bus.out_data  = data_p2_q;
    assign bus.out_sec   = sec_p2_q;
    assign bus.out_ded   = ded_p2_q;
    assign sec_cnt       = sec_cnt_q;
    assign ded_cnt       = ded_cnt_q;

endmodule

// File: tb/tb_ecc_secded_pipe.sv
// tb_ecc_secded_pipe: self-checking bench for ecc_secded_pipe (DW=32).
// A second instance with CNTW=2 exercises counter saturation and clear.
module tb_ecc_secded_pipe;

    logic clk = 1'b0;
    logic rst;
    logic cnt_clr, cnt_clr2;
    logic [15:0] sec_cnt, ded_cnt;
    logic [1:0]  sec_cnt2, ded_cnt2;

    int n_cmp = 0;
    int n_fail = 0;
    int exp_sec = 0;
    int exp_ded = 0;

    always #5 clk = ~clk;

    ecc_secded_pipe_if #(.DW(32)) bus ();
    ecc_secded_pipe_if #(.DW(32)) bus2 ();

    ecc_secded_pipe #(.DW(32), .CNTW(16)) u_dut (
        .clk(clk), .rst(rst), .bus(bus),
        .cnt_clr(cnt_clr), .sec_cnt(sec_cnt), .ded_cnt(ded_cnt)
    );

    ecc_secded_pipe #(.DW(32), .CNTW(2)) u_dut_sat (
        .clk(clk), .rst(rst), .bus(bus2),
        .cnt_clr(cnt_clr2), .sec_cnt(sec_cnt2), .ded_cnt(ded_cnt2)
    );

    // ---------------- reference model (codeword-position view) ----------------
    function automatic int mpos(input int j);
        int cnt;
        int res;
        cnt = 0;
        res = 0;
        for (int k = 1; k < 128; k++) begin
            if ((k & (k - 1)) != 0) begin
                if (cnt == j && res == 0) res = k;
                cnt++;
            end
        end
        return res;
    endfunction

    // Check bits chosen so the XOR of the positions of all set bits is zero.
    function automatic logic [6:0] model_encode(input logic [31:0] d);
        int x;
        logic [6:0] c;
        x = 0;
        for (int j = 0; j < 32; j++) if (d[j]) x = x ^ mpos(j);
        c[5:0] = x[5:0];
        c[6] = (^d) ^ (^x[5:0]);
        return c;
    endfunction

    function automatic void model_decode(input logic [31:0] d, input logic [6:0] c, input bit ce,
                                         output logic [31:0] od, output bit sec, output bit ded);
        int s;
        bit p;
        s = 0;
        for (int j = 0; j < 32; j++) if (d[j]) s = s ^ mpos(j);
        for (int i = 0; i < 6; i++) if (c[i]) s = s ^ (1 << i);
        p = (^d) ^ (^c);
        od = d;
        sec = 0;
        ded = 0;
        if (!p) begin
            ded = (s != 0);
        end else if (s == 0 || (s & (s - 1)) == 0) begin
            sec = 1;
        end else if (s <= 38) begin
            sec = 1;
            if (ce) for (int j = 0; j < 32; j++) if (mpos(j) == s) od[j] = ~od[j];
        end else begin
            ded = 1;
        end
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 0; bus.in_data = '0; bus.in_chk = '0; bus.corr_en = 0; bus.out_ready = 0;
        bus2.in_valid = 0; bus2.in_data = '0; bus2.in_chk = '0; bus2.corr_en = 0; bus2.out_ready = 1;
        cnt_clr = 0; cnt_clr2 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        n_cmp++; if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got=%h want=0", bus.out_data); end
        n_cmp++; if ({bus.out_sec, bus.out_ded} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got=%b%b want=00", bus.out_sec, bus.out_ded); end
        n_cmp++; if (sec_cnt !== 16'd0 || ded_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_counters got=%0d/%0d want=0/0", sec_cnt, ded_cnt); end
    endtask

    // One word with out_ready held high; checks two-cycle latency and result.
    task automatic test_directed(input string name, input logic [31:0] d, input logic [6:0] c, input bit ce,
                                 input logic [31:0] exp_d, input bit exp_s, input bit exp_x);
        @(negedge clk);
        bus.out_ready = 1; bus.in_valid = 1; bus.in_data = d; bus.in_chk = c; bus.corr_en = ce;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_in_ready got=%b want=1", name, bus.in_ready); end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_early_valid got=%b want=0", name, bus.out_valid); end
        @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL %s_valid got=%b want=1", name, bus.out_valid); end
        n_cmp++; if (bus.out_data !== exp_d) begin n_fail++; $display("FAIL %s_data got=%h want=%h", name, bus.out_data, exp_d); end
        n_cmp++; if (bus.out_sec !== exp_s || bus.out_ded !== exp_x) begin n_fail++; $display("FAIL %s_flags got sec=%b ded=%b want sec=%b ded=%b", name, bus.out_sec, bus.out_ded, exp_s, exp_x); end
        @(posedge clk);
        exp_sec += int'(exp_s);
        exp_ded += int'(exp_x);
        @(negedge clk);
        #1;
        n_cmp++; if (sec_cnt !== 16'(exp_sec) || ded_cnt !== 16'(exp_ded)) begin n_fail++; $display("FAIL %s_counters got=%0d/%0d want=%0d/%0d", name, sec_cnt, ded_cnt, exp_sec, exp_ded); end
    endtask

    task automatic test_clean();
        test_directed("clean", 32'h1, 7'h43, 1'b1, 32'h1, 1'b0, 1'b0);
    endtask

    task automatic test_single();
        test_directed("sec_corr", 32'h3, 7'h43, 1'b1, 32'h1, 1'b1, 1'b0);
        test_directed("sec_detect", 32'h3, 7'h43, 1'b0, 32'h3, 1'b1, 1'b0);
    endtask

    task automatic test_double();
        test_directed("ded", 32'h7, 7'h43, 1'b1, 32'h7, 1'b0, 1'b1);
        test_directed("chk_err", 32'h1, 7'h03, 1'b1, 32'h1, 1'b1, 1'b0);
    endtask

    // rdy_mode: 0 always ready, 1 pattern 1,0,0 repeating, 2 random.
    // err_mode: 0 none, 1 single flip, 4 mix of 0/1/2 flips and random chk.
    task automatic test_stream(input string name, input int nwords, input int rdy_mode, input int err_mode);
        logic [31:0] qd[$];
        bit qs[$];
        bit qx[$];
        logic [31:0] cur_d, hold_d, md;
        logic [6:0] cur_c;
        bit cur_ce, have, stalled, hold_s, hold_x, ms, mx;
        int sent, got, cyc, k, b, b0;
        sent = 0; got = 0; cyc = 0; have = 0; stalled = 0;
        cur_d = '0; cur_c = '0; cur_ce = 0; hold_d = '0; hold_s = 0; hold_x = 0; b0 = -1;
        while (got < nwords && cyc < nwords * 20 + 50) begin
            @(negedge clk);
            case (rdy_mode)
                0: bus.out_ready = 1;
                1: bus.out_ready = ((cyc % 3) == 0);
                default: bus.out_ready = ($urandom_range(0, 2) != 0);
            endcase
            if (!have && sent < nwords) begin
                cur_d = $urandom;
                cur_c = model_encode(cur_d);
                cur_ce = ($urandom_range(0, 3) != 0);
                k = (err_mode == 4) ? $urandom_range(0, 3) : err_mode;
                if (k == 3) begin
                    cur_c = 7'($urandom);
                end else begin
                    for (int f = 0; f < k; f++) begin
                        b = $urandom_range(0, 38);
                        if (f == 1 && b == b0) b = (b + 1) % 39;
                        b0 = b;
                        if (b < 32) cur_d[b] = ~cur_d[b];
                        else cur_c[b-32] = ~cur_c[b-32];
                    end
                end
                have = 1;
            end
            bus.in_valid = have && (rdy_mode != 2 || $urandom_range(0, 3) != 0);
            bus.in_data = cur_d; bus.in_chk = cur_c; bus.corr_en = cur_ce;
            #1;
            if (stalled) begin
                n_cmp++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== hold_d || bus.out_sec !== hold_s || bus.out_ded !== hold_x) begin
                    n_fail++;
                    $display("FAIL %s_hold got v=%b d=%h s=%b x=%b want v=1 d=%h s=%b x=%b", name,
                             bus.out_valid, bus.out_data, bus.out_sec, bus.out_ded, hold_d, hold_s, hold_x);
                end
            end
            n_cmp++;
            if (bus.in_ready !== ((qd.size() < 2) || bus.out_ready)) begin
                n_fail++;
                $display("FAIL %s_in_ready got=%b want=%b inflight=%0d", name, bus.in_ready, (qd.size() < 2) || bus.out_ready, qd.size());
            end
            stalled = bus.out_valid && !bus.out_ready;
            hold_d = bus.out_data; hold_s = bus.out_sec; hold_x = bus.out_ded;
            if (bus.out_valid && bus.out_ready) begin
                n_cmp++;
                if (qd.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s_extra got=%h want=none", name, bus.out_data);
                end else begin
                    md = qd.pop_front(); ms = qs.pop_front(); mx = qx.pop_front();
                    if (bus.out_data !== md || bus.out_sec !== ms || bus.out_ded !== mx) begin
                        n_fail++;
                        $display("FAIL %s_word%0d got d=%h s=%b x=%b want d=%h s=%b x=%b", name, got,
                                 bus.out_data, bus.out_sec, bus.out_ded, md, ms, mx);
                    end
                    exp_sec += int'(ms);
                    exp_ded += int'(mx);
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                model_decode(cur_d, cur_c, cur_ce, md, ms, mx);
                qd.push_back(md); qs.push_back(ms); qx.push_back(mx);
                have = 0;
                sent++;
            end
            cyc++;
            @(posedge clk);
        end
        @(negedge clk);
        bus.in_valid = 0;
        bus.out_ready = 1;
        #1;
        n_cmp++; if (got != nwords) begin n_fail++; $display("FAIL %s_timeout got=%0d want=%0d", name, got, nwords); end
        n_cmp++; if (sec_cnt !== 16'(exp_sec) || ded_cnt !== 16'(exp_ded)) begin n_fail++; $display("FAIL %s_counters got=%0d/%0d want=%0d/%0d", name, sec_cnt, ded_cnt, exp_sec, exp_ded); end
    endtask

    task automatic test_back_to_back();
        test_stream("b2b", 40, 0, 4);
    endtask

    task automatic test_backpressure();
        test_stream("bp", 8, 1, 4);
    endtask

    task automatic test_random();
        test_stream("rand", 300, 2, 4);
    endtask

    task automatic test_counters_sat();
        bus2.out_ready = 1;
        bus2.in_data = 32'h3; bus2.in_chk = 7'h43; bus2.corr_en = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus2.in_valid = 1;
            #1;
            n_cmp++; if (bus2.in_ready !== 1'b1) begin n_fail++; $display("FAIL sat_in_ready%0d got=%b want=1", i, bus2.in_ready); end
        end
        @(negedge clk);
        bus2.in_valid = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++; if (sec_cnt2 !== 2'd3) begin n_fail++; $display("FAIL sat_sec_cnt got=%0d want=3", sec_cnt2); end
        n_cmp++; if (ded_cnt2 !== 2'd0) begin n_fail++; $display("FAIL sat_ded_cnt got=%0d want=0", ded_cnt2); end
        // Clear collides with a SEC handshake: the increment is lost.
        bus2.in_valid = 1;
        @(posedge clk);
        @(negedge clk);
        bus2.in_valid = 0;
        @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++; if (bus2.out_valid !== 1'b1) begin n_fail++; $display("FAIL clr_out_valid got=%b want=1", bus2.out_valid); end
        cnt_clr2 = 1;
        @(posedge clk);
        @(negedge clk);
        cnt_clr2 = 0;
        #1;
        n_cmp++; if (sec_cnt2 !== 2'd0) begin n_fail++; $display("FAIL clr_sec_cnt got=%0d want=0", sec_cnt2); end
        bus2.in_valid = 1;
        @(posedge clk);
        @(negedge clk);
        bus2.in_valid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++; if (sec_cnt2 !== 2'd1) begin n_fail++; $display("FAIL post_clr_sec_cnt got=%0d want=1", sec_cnt2); end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        bus.out_ready = 0;
        bus.in_valid = 1; bus.in_data = 32'h7; bus.in_chk = 7'h43; bus.corr_en = 1;
        @(posedge clk);
        @(negedge clk);
        bus.in_data = 32'h3;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 0;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got=%b want=0", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL full_out_valid got=%b want=1", bus.out_valid); end
        #1;
        rst = 1;
        #1;
        exp_sec = 0;
        exp_ded = 0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got=%b want=0", bus.out_valid); end
        n_cmp++; if (sec_cnt !== 16'd0 || ded_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_counters got=%0d/%0d want=0/0", sec_cnt, ded_cnt); end
        @(negedge clk);
        rst = 0;
        bus.out_ready = 1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got=%b want=1", bus.in_ready); end
        test_directed("after_rst", 32'h3, 7'h43, 1'b1, 32'h1, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single();
        test_double();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_counters_sat();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
